// File: rtl/lemming_4.sv
// Lemming walker FSM: walk left/right, fall, dig, splat on over-long falls.
// Latency: one clk edge from any input to the outputs; no backpressure (level-world stimulus).
module lemming_4 #(
   parameter int SPLAT_CYCLES = 20,
   parameter bit RESET_DIR    = 1'b0
) (
   input  logic clk,
   input  logic areset,
   input  logic bump_left,
   input  logic bump_right,
   input  logic ground,
   input  logic dig,
   output logic walk_left,
   output logic walk_right,
   output logic aaah,
   output logic digging
);

   localparam int CNT_W = $clog2(SPLAT_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SPLAT_CYCLES);

   typedef enum logic [2:0] {
      WL    = 3'd0,
      WR    = 3'd1,
      FL    = 3'd2,
      FR    = 3'd3,
      DL    = 3'd4,
      DR    = 3'd5,
      SPLAT = 3'd6
   } state_t;

   localparam state_t RST_ST = RESET_DIR ? WR : WL;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q    <= RST_ST;
         fall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fall_cnt_q <= fall_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fall_cnt_d = '0;
      case (state_q)
         WL: begin
            if (!ground)        state_d = FL;
            else if (dig)       state_d = DL;
            else if (bump_left) state_d = WR;
         end
         WR: begin
            if (!ground)         state_d = FR;
            else if (dig)        state_d = DR;
            else if (bump_right) state_d = WL;
         end
         DL: if (!ground) state_d = FL;
         DR: if (!ground) state_d = FR;
         FL, FR: begin
            if (!ground) begin
               // Saturate so arbitrarily long falls still register as fatal.
               fall_cnt_d = (fall_cnt_q >= CNT_SAT) ? CNT_SAT : fall_cnt_q + CNT_W'(1);
            end else if (fall_cnt_q >= CNT_SAT) begin
               state_d = SPLAT;
            end else begin
               state_d = (state_q == FL) ? WL : WR;
            end
         end
         SPLAT: state_d = SPLAT;
         default: state_d = RST_ST;
      endcase
   end

   always_comb begin
      walk_left  = 1'b0;
      walk_right = 1'b0;
      aaah       = 1'b0;
      digging    = 1'b0;
      case (state_q)
         WL:      walk_left  = 1'b1;
         WR:      walk_right = 1'b1;
         FL, FR:  aaah       = 1'b1;
         DL, DR:  digging    = 1'b1;
         default: ;
      endcase
   end

endmodule
